// File: rtl/ifu_imem_responder.sv
// ifu_imem_responder
// Instruction-memory read responder on the far side of the IFU fetch
// interface. A level-held fetch request is captured in IDLE, the addressed
// doubleword is returned LATENCY edges later with a one-cycle RD_DONE pulse,
// and the block then waits in DRAIN until the IFU drops RD_REQ so that a
// still-held request is never served twice.
//
// Parameters
//   LATENCY     edges from request capture to the RESP state (legal 1..15)
//   DEPTH_LOG2  array holds 2**DEPTH_LOG2 doublewords
//   BASE_ADDR   byte address of doubleword 0
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   RD_REQ   fetch request, level-held until RD_DONE is seen
//   RD_ADDR  fetch byte address, sampled only on capture
//   RD_DONE  one-cycle response pulse
//   RD_DATA  response doubleword, held until the next response
//   RD_ERR   response error (out of range or misaligned), held likewise
//   BUSY     high whenever the FSM is not IDLE
//   LD_EN    preload write enable (honoured in every state, even in reset)
//   LD_ADDR  preload doubleword index
//   LD_DATA  preload data
module ifu_imem_responder #(
  parameter int          LATENCY    = 2,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RD_REQ,
  input  logic [63:0]           RD_ADDR,
  output logic                  RD_DONE,
  output logic [63:0]           RD_DATA,
  output logic                  RD_ERR,
  output logic                  BUSY,
  input  logic                  LD_EN,
  input  logic [DEPTH_LOG2-1:0] LD_ADDR,
  input  logic [63:0]           LD_DATA
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [63:0]     addr_q;
  logic            capture;
  logic            load_resp;

  logic [63:0]     mem [DEPTH];

  // Doubleword offset from the base; addresses below BASE_ADDR wrap to a
  // huge offset and therefore fall out of range naturally.
  logic [63:0]           off_dw;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  aligned;

  assign off_dw   = (addr_q - BASE_ADDR) >> 3;
  assign idx      = off_dw[DEPTH_LOG2-1:0];
  assign in_range = ~|off_dw[63:DEPTH_LOG2];
  // addr_q[2] is deliberately ignored: the containing doubleword is returned.
  assign aligned  = (addr_q[1:0] == 2'b00);

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    load_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RD_REQ) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          load_resp = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:  state_d = DRAIN;
      DRAIN: if (!RD_REQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and response registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is also what gives a same-edge load/read
  // collision the old array contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      RD_DATA <= 64'h0;
      RD_ERR  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_resp) begin
        if (in_range && aligned) begin
          RD_DATA <= mem[idx];
          RD_ERR  <= 1'b0;
        end else begin
          RD_DATA <= 64'h0;
          RD_ERR  <= 1'b1;
        end
      end
    end
  end

  // Captured fetch address; only meaningful after a capture, so it needs no
  // reset value.
  always_ff @(posedge clk) begin
    if (capture) addr_q <= RD_ADDR;
  end

  // Program image. Preloads are accepted in every state, including while
  // reset is asserted.
  // NOTE: the array is intentionally left out of reset so it maps onto plain
  // RAM and a program loaded during reset survives it.
  always_ff @(posedge clk) begin
    if (LD_EN) mem[LD_ADDR] <= LD_DATA;
  end

  assign RD_DONE = (state_q == RESP);
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_ifu_imem_responder.sv
// Self-checking bench for ifu_imem_responder. Two instances share the clock
// and the preload bus: dut runs with LATENCY=2 for the main fetch scenarios,
// dut4 runs with LATENCY=4 for the mid-WAIT reset scenario. Stimulus pushes
// the expected response (data, error, arrival cycle) into a queue; a monitor
// per instance pops and compares whenever RD_DONE is seen.
module tb_ifu_imem_responder;

  localparam int LAT  = 2;
  localparam int LAT4 = 4;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        rd_req, req4;
  logic [63:0] rd_addr;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [63:0] ld_data;

  logic        rd_done, rd_err, busy;
  logic [63:0] rd_data;
  logic        done4, err4, busy4;
  logic [63:0] data4;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   done_cnt = 0;
  int   done4_cnt = 0;
  exp_t sb_q[$];
  exp_t sb4_q[$];
  exp_t mon_e, mon4_e;

  ifu_imem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .RD_REQ(rd_req), .RD_ADDR(rd_addr),
    .RD_DONE(rd_done), .RD_DATA(rd_data), .RD_ERR(rd_err), .BUSY(busy),
    .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_DATA(ld_data)
  );

  ifu_imem_responder #(.LATENCY(LAT4)) dut4 (
    .clk(clk), .rst(rst4), .RD_REQ(req4), .RD_ADDR(rd_addr),
    .RD_DONE(done4), .RD_DATA(data4), .RD_ERR(err4), .BUSY(busy4),
    .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_DATA(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare every RD_DONE pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rd_done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_data", rd_data, mon_e.data);
        check("rd_err", 64'(rd_err), 64'(mon_e.err));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      done4_cnt++;
      if (sb4_q.size() == 0) begin
        check("spurious_done4", 64'(sb4_q.size()), 64'd1);
      end else begin
        mon4_e = sb4_q.pop_front();
        check("rd_data4", data4, mon4_e.data);
        check("rd_err4", 64'(err4), 64'(mon4_e.err));
        check("done_cycle4", 64'(cyc), 64'(mon4_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic preload(input logic [11:0] i, input logic [63:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = i;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // One fetch on dut. hold: cycles to keep RD_REQ high after RD_DONE.
  // collide: write cval into index cidx on the response edge.
  // early: drop RD_REQ while the request is still in WAIT.
  task automatic fetch(input logic [63:0] a, input logic [63:0] d, input logic e,
                       input int hold, input bit collide, input logic [11:0] cidx,
                       input logic [63:0] cval, input bit early);
    bit seen;
    int dc0;
    dc0  = done_cnt;
    seen = 1'b0;
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    sb_q.push_back('{data: d, err: e, cyc: cyc + 1 + LAT});
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rd_addr = ~a;             // post-capture address changes must be ignored
        if (early) rd_req = 1'b0;
      end
      ld_en = collide && (i == 1);
      if (collide && i == 1) begin
        ld_addr = cidx;
        ld_data = cval;
      end
      if (rd_done === 1'b1) seen = 1'b1;
    end
    ld_en = 1'b0;
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("busy_while_held", 64'(busy), 64'd1);
    end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_after_drain", 64'(busy), 64'd0);
    check("single_pulse", 64'(done_cnt - dc0), 64'd1);
  endtask

  task automatic fetch4(input logic [63:0] a, input logic [63:0] d);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    rd_addr = a;
    req4    = 1'b1;
    sb4_q.push_back('{data: d, err: 1'b0, cyc: cyc + 1 + LAT4});
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) seen = 1'b1;
    end
    if (!seen) check("done4_timeout", 64'(seen), 64'd1);
    req4 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy4_after_drain", 64'(busy4), 64'd0);
  endtask

  localparam logic [63:0] W0   = 64'h0000_0013_0000_0093;
  localparam logic [63:0] W1   = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] W2   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WA   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] WB   = 64'h5555_6666_7777_8888;
  localparam logic [63:0] WTOP = 64'hFFEE_DDCC_BBAA_9988;

  initial begin
    int d0;
    rst     = 1'b0;
    rst4    = 1'b0;
    rd_req  = 1'b0;
    req4    = 1'b0;
    rd_addr = 64'h0;
    ld_en   = 1'b0;
    ld_addr = 12'h0;
    ld_data = 64'h0;

    // Preload while reset is asserted, then check reset values.
    preload(12'd0, W0);
    check("rst_done", 64'(rd_done), 64'd0);
    check("rst_data", rd_data, 64'h0);
    check("rst_err", 64'(rd_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    rst4 = 1'b1;

    preload(12'd1, W1);
    preload(12'd2, W2);
    preload(12'd3, WA);
    preload(12'd4095, WTOP);

    // Basic fetch, then the same request held for 10 cycles past RD_DONE,
    // then a fresh request after the 0->1 toggle (addr[2] ignored).
    fetch(64'h8000_0000, W0, 1'b0, 0, 1'b0, 12'd0, 64'h0, 1'b0);
    fetch(64'h8000_0000, W0, 1'b0, 10, 1'b0, 12'd0, 64'h0, 1'b0);
    fetch(64'h8000_000C, W1, 1'b0, 0, 1'b0, 12'd0, 64'h0, 1'b0);

    // Range and alignment boundaries.
    fetch(64'h7FFF_FFF8, 64'h0, 1'b1, 0, 1'b0, 12'd0, 64'h0, 1'b0);
    fetch(64'h8000_7FF8, WTOP, 1'b0, 0, 1'b0, 12'd0, 64'h0, 1'b0);
    fetch(64'h8000_0002, 64'h0, 1'b1, 0, 1'b0, 12'd0, 64'h0, 1'b0);
    fetch(64'h8000_8000, 64'h0, 1'b1, 0, 1'b0, 12'd0, 64'h0, 1'b0);

    // Load/read collision on index 3: old data now, new data next time.
    fetch(64'h8000_0018, WA, 1'b0, 0, 1'b1, 12'd3, WB, 1'b0);
    fetch(64'h8000_0018, WB, 1'b0, 0, 1'b0, 12'd0, 64'h0, 1'b0);

    // Request dropped during WAIT still completes.
    fetch(64'h8000_0010, W2, 1'b0, 0, 1'b0, 12'd0, 64'h0, 1'b1);

    // LATENCY=4 instance: a normal fetch leaves RD_DATA non-zero, then a
    // reset one edge after capture aborts the next one.
    fetch4(64'h8000_0008, W1);
    d0 = done4_cnt;
    @(negedge clk);
    rd_addr = 64'h8000_0010;
    req4    = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    check("midrst_done4", 64'(done4), 64'd0);
    check("midrst_data4", data4, 64'h0);
    check("midrst_err4", 64'(err4), 64'd0);
    check("midrst_busy4", 64'(busy4), 64'd0);
    @(negedge clk);
    check("midrst_busy4_hold", 64'(busy4), 64'd0);
    rst4 = 1'b1;
    sb4_q.push_back('{data: W2, err: 1'b0, cyc: cyc + 1 + LAT4});
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done4 === 1'b1) seen = 1'b1;
      end
      if (!seen) check("recapture_timeout", 64'(seen), 64'd1);
    end
    req4 = 1'b0;
    repeat (2) @(negedge clk);
    check("recapture_single_pulse", 64'(done4_cnt - d0), 64'd1);
    check("busy4_final", 64'(busy4), 64'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("sb4_empty", 64'(sb4_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
